// File: rtl/pll_phase_ctrl_if.sv
// Command handshake between a host and the PLL phase controller.
// The host drives a phase-step request; the controller answers with CMD_READY.
interface pll_phase_ctrl_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_SEL;
  logic       CMD_DIR;
  logic [3:0] CMD_STEPS;

  modport master (output CMD_VALID, CMD_SEL, CMD_DIR, CMD_STEPS, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_SEL, CMD_DIR, CMD_STEPS, output CMD_READY);
endinterface

// File: rtl/pll_phase_ctrl.sv
// PLL reset/lock sequencer with dynamic phase stepping of CLKOP..CLKOS3.
// Keeps a 3-bit phase position per output and counts relock events.
module pll_phase_ctrl #(
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOSS_FILT    = 4,
  parameter int STEP_W       = 4
) (
  input  logic            CLKI,
  input  logic            RST,
  input  logic            LOCK,
  pll_phase_ctrl_if.slave cmd,
  output logic [1:0]      PHASESEL,
  output logic            PHASEDIR,
  output logic            PHASESTEP,
  output logic            PHASELOADREG,
  output logic            PLL_RST,
  output logic            LOCKED,
  output logic            BUSY,
  output logic            DONE,
  output logic [11:0]     PHASE_POS,
  output logic [7:0]      RELOCK_CNT
);

  localparam int CNT_MAX = (PLL_RST_CYC > STEP_W) ? PLL_RST_CYC : STEP_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int LOSS_W  = $clog2(LOSS_FILT + 1);

  typedef enum logic [2:0] {
    ST_RESET_PLL, ST_WAIT_LOCK, ST_IDLE, ST_SETUP,
    ST_STEP_HI, ST_STEP_LO, ST_LOAD, ST_DONE
  } state_t;

  typedef struct packed {
    logic       pll_rst;
    logic       ready;
    logic       locked;
    logic       busy;
    logic       done;
    logic       step;
    logic       load;
    logic       dir;
    logic [1:0] sel;
  } outs_t;

  localparam outs_t OUTS_RST = '{pll_rst: 1'b1, ready: 1'b0, locked: 1'b0, busy: 1'b1,
                                 done: 1'b0, step: 1'b0, load: 1'b0, dir: 1'b0, sel: 2'b00};

  state_t              state, state_nx;
  outs_t               out_d, out_q;
  logic                lock_meta, lock_sync;
  logic [CNT_W-1:0]    cnt;
  logic [STB_W-1:0]    stb_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [LOSS_W-1:0]   loss_cnt;
  logic [3:0]          steps_q;
  logic [1:0]          sel_q;
  logic                dir_q;
  logic [3:0][2:0]     pos_q;
  logic [7:0]          relock_q;

  logic timed, rst_done, ph_done, stable_hit, timeout, loss, accept, rst_entry, step_entry;

  assign timed      = state inside {ST_RESET_PLL, ST_SETUP, ST_STEP_HI, ST_STEP_LO, ST_LOAD};
  assign rst_done   = (cnt == CNT_W'(PLL_RST_CYC - 1));
  assign ph_done    = (cnt == CNT_W'(STEP_W - 1));
  assign stable_hit = lock_sync && (stb_cnt == STB_W'(LOCK_STABLE - 1));
  assign timeout    = (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));
  assign loss       = !lock_sync && (loss_cnt == LOSS_W'(LOSS_FILT - 1));
  assign accept     = (state == ST_IDLE) && cmd.CMD_VALID && !loss;
  assign rst_entry  = (state_nx == ST_RESET_PLL) && (state != ST_RESET_PLL);
  assign step_entry = (state_nx == ST_STEP_HI) && (state != ST_STEP_HI);

  // State register, counters and captured command.
  always_ff @(posedge CLKI) begin
    if (RST) begin
      // NOTE: synchronous reset clears every flop in this block, including the synchronizer.
      state     <= ST_RESET_PLL;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      cnt       <= '0;
      stb_cnt   <= '0;
      tmo_cnt   <= '0;
      loss_cnt  <= '0;
      steps_q   <= '0;
      sel_q     <= '0;
      dir_q     <= 1'b0;
      pos_q     <= '0;
      relock_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_nx;
      lock_meta <= LOCK;
      lock_sync <= lock_meta;
      cnt       <= (timed && state_nx == state) ? cnt + CNT_W'(1) : '0;
      stb_cnt   <= (state == ST_WAIT_LOCK && lock_sync) ? stb_cnt + STB_W'(1) : '0;
      tmo_cnt   <= (state == ST_WAIT_LOCK && state_nx == ST_WAIT_LOCK) ? tmo_cnt + TMO_W'(1) : '0;
      loss_cnt  <= (state == ST_IDLE && state_nx == ST_IDLE && !lock_sync) ?
                   loss_cnt + LOSS_W'(1) : '0;
      if (accept) begin
        steps_q <= cmd.CMD_STEPS;
        sel_q   <= cmd.CMD_SEL;
        dir_q   <= cmd.CMD_DIR;
      end else if (state == ST_STEP_LO && ph_done) begin
        steps_q <= steps_q - 4'd1;
      end
      // Position is counted on the rising edge of each step, wrapping modulo 8.
      if (rst_entry) begin
        pos_q <= '0;
        if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
      end else if (step_entry) begin
        pos_q[sel_q] <= dir_q ? pos_q[sel_q] - 3'd1 : pos_q[sel_q] + 3'd1;
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first so no branch leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      ST_RESET_PLL: if (rst_done) state_nx = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (stable_hit)   state_nx = ST_IDLE;
        else if (timeout) state_nx = ST_RESET_PLL;
      end
      // Loss of lock outranks a command presented in the same cycle.
      ST_IDLE: begin
        if (loss)        state_nx = ST_RESET_PLL;
        else if (accept) state_nx = (cmd.CMD_STEPS == 4'd0) ? ST_DONE : ST_SETUP;
      end
      ST_SETUP:   if (ph_done) state_nx = ST_STEP_HI;
      ST_STEP_HI: if (ph_done) state_nx = ST_STEP_LO;
      ST_STEP_LO: if (ph_done) state_nx = (steps_q == 4'd1) ? ST_LOAD : ST_STEP_HI;
      ST_LOAD:    if (ph_done) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state.
  always_comb begin
    out_d        = '0;
    out_d.pll_rst = (state_nx == ST_RESET_PLL);
    out_d.ready   = (state_nx == ST_IDLE);
    out_d.busy    = (state_nx != ST_IDLE);
    out_d.locked  = !(state_nx inside {ST_RESET_PLL, ST_WAIT_LOCK});
    out_d.done    = (state_nx == ST_DONE);
    out_d.step    = (state_nx == ST_STEP_HI);
    out_d.load    = (state_nx == ST_LOAD);
    if (state_nx inside {ST_SETUP, ST_STEP_HI, ST_STEP_LO, ST_LOAD}) begin
      out_d.sel = accept ? cmd.CMD_SEL : sel_q;
      out_d.dir = accept ? cmd.CMD_DIR : dir_q;
    end
  end

  always_ff @(posedge CLKI) begin
    if (RST) out_q <= OUTS_RST;
    else     out_q <= out_d;
  end

  assign PLL_RST       = out_q.pll_rst;
  assign cmd.CMD_READY = out_q.ready;
  assign LOCKED        = out_q.locked;
  assign BUSY          = out_q.busy;
  assign DONE          = out_q.done;
  assign PHASESTEP     = out_q.step;
  assign PHASELOADREG  = out_q.load;
  assign PHASEDIR      = out_q.dir;
  assign PHASESEL      = out_q.sel;
  assign PHASE_POS     = pos_q;
  assign RELOCK_CNT    = relock_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: power-up, stepping table, loss of lock,
// lock timeout, reset mid-command and loss-versus-command collision.
module tb_pll_phase_ctrl;

  logic        CLKI = 1'b0;
  logic        RST, LOCK;
  logic [1:0]  PHASESEL;
  logic        PHASEDIR, PHASESTEP, PHASELOADREG, PLL_RST, LOCKED, BUSY, DONE;
  logic [11:0] PHASE_POS;
  logic [7:0]  RELOCK_CNT;

  int errors = 0;
  int checks = 0;

  pll_phase_ctrl_if cmd ();

  pll_phase_ctrl dut (
    .CLKI         (CLKI),
    .RST          (RST),
    .LOCK         (LOCK),
    .cmd          (cmd),
    .PHASESEL     (PHASESEL),
    .PHASEDIR     (PHASEDIR),
    .PHASESTEP    (PHASESTEP),
    .PHASELOADREG (PHASELOADREG),
    .PLL_RST      (PLL_RST),
    .LOCKED       (LOCKED),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .PHASE_POS    (PHASE_POS),
    .RELOCK_CNT   (RELOCK_CNT)
  );

  always #5 CLKI = ~CLKI;

  typedef struct {
    logic [1:0]  sel;
    logic        dir;
    logic [3:0]  steps;
    int          latency;
    int          pulses;
    int          step_cyc;
    int          load_cyc;
    logic [11:0] pos;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKI);
    #1;
  endtask

  task automatic wait_pll_rst(input string name, input logic lvl, input int budget, output int n);
    n = 0;
    while (PLL_RST !== lvl && n < budget) begin
      tick();
      n++;
    end
    check({name, "_pll_rst_level"}, PLL_RST, lvl);
  endtask

  task automatic wait_locked(input string name, input int budget, output int n);
    n = 0;
    while (LOCKED !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_locked"}, LOCKED, 1);
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    int   lat, pulses, step_cyc, load_cyc, bad_sel, not_busy;
    logic prev_step, seen;
    string tag;
    tag = $sformatf("cmd%0d", idx);
    check({tag, "_ready_before"}, cmd.CMD_READY, 1);
    cmd.CMD_VALID = 1'b1;
    cmd.CMD_SEL   = v.sel;
    cmd.CMD_DIR   = v.dir;
    cmd.CMD_STEPS = v.steps;
    lat = 0; pulses = 0; step_cyc = 0; load_cyc = 0; bad_sel = 0; not_busy = 0;
    prev_step = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      tick();
      cmd.CMD_VALID = 1'b0;
      lat++;
      if (PHASESTEP && !prev_step) pulses++;
      prev_step = PHASESTEP;
      if (PHASESTEP)    step_cyc++;
      if (PHASELOADREG) load_cyc++;
      if ((PHASESTEP || PHASELOADREG) && (PHASESEL !== v.sel || PHASEDIR !== v.dir)) bad_sel++;
      if (!BUSY || !LOCKED) not_busy++;
      seen = DONE;
    end
    check({tag, "_latency"},    lat,      v.latency);
    check({tag, "_pulses"},     pulses,   v.pulses);
    check({tag, "_step_cyc"},   step_cyc, v.step_cyc);
    check({tag, "_load_cyc"},   load_cyc, v.load_cyc);
    check({tag, "_sel_dir"},    bad_sel,  0);
    check({tag, "_busy_lock"},  not_busy, 0);
    check({tag, "_phase_pos"},  PHASE_POS, v.pos);
    tick();
    check({tag, "_done_width"}, DONE, 0);
    check({tag, "_ready_after"}, cmd.CMD_READY, 1);
  endtask

  initial begin
    int n, bad;

    //             sel   dir   steps lat  pul stc ldc  pos
    vecs[0] = '{2'd1, 1'b0, 4'd3,  33,  3, 12, 4, 12'h018};
    vecs[1] = '{2'd0, 1'b1, 4'd1,  17,  1,  4, 4, 12'h01F};
    vecs[2] = '{2'd0, 1'b1, 4'd0,   1,  0,  0, 0, 12'h01F};
    vecs[3] = '{2'd3, 1'b0, 4'd2,  25,  2,  8, 4, 12'h41F};
    vecs[4] = '{2'd1, 1'b1, 4'd5,  49,  5, 20, 4, 12'h437};
    vecs[5] = '{2'd2, 1'b0, 4'd15, 129, 15, 60, 4, 12'h5F7};
    vecs[6] = '{2'd0, 1'b0, 4'd1,  17,  1,  4, 4, 12'h5F0};

    RST = 1'b1;
    LOCK = 1'b0;
    cmd.CMD_VALID = 1'b0;
    cmd.CMD_SEL   = 2'd0;
    cmd.CMD_DIR   = 1'b0;
    cmd.CMD_STEPS = 4'd0;

    // Power-up.
    repeat (5) tick();
    check("rst_pll_rst", PLL_RST, 1);
    check("rst_busy", BUSY, 1);
    check("rst_zero_outputs",
          {PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG, cmd.CMD_READY, LOCKED, DONE, PHASE_POS, RELOCK_CNT}, 0);
    RST = 1'b0;
    wait_pll_rst("pwr", 1'b0, 100, n);
    check("pwr_pll_rst_cycles", n, 16);
    repeat (10) tick();
    LOCK = 1'b1;
    wait_locked("pwr", 200, n);
    check("pwr_lock_latency", n, 66);
    check("pwr_ready", cmd.CMD_READY, 1);
    check("pwr_busy", BUSY, 0);

    for (int i = 0; i < 7; i++) run_cmd(vecs[i], i);

    // Short LOCK glitch in IDLE is filtered out.
    LOCK = 1'b0;
    repeat (3) tick();
    LOCK = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (PLL_RST || !cmd.CMD_READY) bad++;
    end
    check("glitch_no_action", bad, 0);

    // Real loss of lock.
    LOCK = 1'b0;
    wait_pll_rst("loss", 1'b1, 50, n);
    check("loss_latency", n, 6);
    check("loss_relock_cnt", RELOCK_CNT, 1);
    check("loss_pos_cleared", PHASE_POS, 0);
    check("loss_locked", LOCKED, 0);

    // LOCK stays low: WAIT_LOCK times out.
    wait_pll_rst("tmo_a", 1'b0, 50, n);
    check("tmo_pll_rst_cycles", n, 16);
    wait_pll_rst("tmo_b", 1'b1, 70000, n);
    check("tmo_wait_cycles", n, 65535);
    check("tmo_relock_cnt", RELOCK_CNT, 2);

    // Relock, then reset mid-command.
    LOCK = 1'b1;
    wait_pll_rst("relock", 1'b0, 50, n);
    wait_locked("relock", 200, n);
    check("relock_latency", n, 64);
    cmd.CMD_VALID = 1'b1;
    cmd.CMD_SEL   = 2'd2;
    cmd.CMD_DIR   = 1'b0;
    cmd.CMD_STEPS = 4'd3;
    tick();
    cmd.CMD_VALID = 1'b0;
    n = 0;
    while (PHASESTEP !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("abort_step_seen", PHASESTEP, 1);
    check("abort_pos_before", PHASE_POS, 12'h040);
    RST = 1'b1;
    tick();
    check("abort_step_low", PHASESTEP, 0);
    check("abort_done_low", DONE, 0);
    check("abort_pll_rst", PLL_RST, 1);
    check("abort_counters", {PHASE_POS, RELOCK_CNT}, 0);
    RST = 1'b0;
    bad = 0;
    repeat (40) begin
      tick();
      if (DONE || PHASELOADREG || PHASESTEP) bad++;
    end
    check("abort_no_tail", bad, 0);

    // Command presented on the very cycle the loss threshold is reached.
    wait_locked("collide", 200, n);
    LOCK = 1'b0;
    repeat (5) tick();
    check("collide_ready_pre", cmd.CMD_READY, 1);
    cmd.CMD_VALID = 1'b1;
    cmd.CMD_SEL   = 2'd1;
    cmd.CMD_DIR   = 1'b0;
    cmd.CMD_STEPS = 4'd2;
    tick();
    cmd.CMD_VALID = 1'b0;
    check("collide_pll_rst", PLL_RST, 1);
    check("collide_ready", cmd.CMD_READY, 0);
    check("collide_relock_cnt", RELOCK_CNT, 1);
    bad = 0;
    repeat (20) begin
      tick();
      if (PHASESTEP || DONE || PHASELOADREG) bad++;
    end
    check("collide_no_cmd", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
